// File: rtl/risc_v_multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path.
// The ALU, operand muxes, result mux and immediate extender of the datapath
// use these same encodings, so they are kept here in one place.
// No ports: package only (state enum, opcode constants, select encodings).
package risc_v_multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LINK    = 4'd12,
    S_LUI     = 4'd13
  } state_e;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_XOR  = 3'b110
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_e;

  typedef enum logic [1:0] {
    A_PC    = 2'b00,
    A_OLDPC = 2'b01,
    A_REG   = 2'b10,
    A_ZERO  = 2'b11
  } in_a_e;

  typedef enum logic [1:0] {
    B_REG   = 2'b00,
    B_IMM   = 2'b01,
    B_FOUR  = 2'b10,
    B_ZERO  = 2'b11
  } in_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MDR       = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } res_e;

endpackage

// File: rtl/risc_v_multicycle_controller_alu_decoder.sv
// Combinational funct decode: picks the ALU operation for R/I arithmetic.
// Ports:
//   opcode     in  7  instr[6:0]
//   func3      in  3  instr[14:12]
//   func7      in  1  instr[30]
//   alu_opcode out 3  ALU operation encoding
module risc_v_alu_decoder
  import risc_v_multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic [2:0] alu_opcode
);

  // Func3 to ALU operation; the shift encodings 001/101 map to add.
  always_comb begin
    alu_opcode = ALU_ADD;
    case (func3)
      3'b000: begin
        // Only R-type uses instr[30] to select sub; addi ignores it.
        if ((opcode == OP_R_ALU) && func7) begin
          alu_opcode = ALU_SUB;
        end else begin
          alu_opcode = ALU_ADD;
        end
      end
      3'b111:  alu_opcode = ALU_AND;
      3'b110:  alu_opcode = ALU_OR;
      3'b100:  alu_opcode = ALU_XOR;
      3'b010:  alu_opcode = ALU_SLT;
      3'b011:  alu_opcode = ALU_SLTU;
      default: alu_opcode = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/risc_v_multicycle_controller.sv
// Moore-style control FSM for the multi-cycle RISC-V datapath.
// Ports:
//   clk, rst (sync, active-high)
//   Opcode/Func3/Func7      instruction fields from the IR
//   ZeroFlag/NegFlag        ALU flags, used only for branch resolution
//   PCWrite AdrSlc MemWrite IRWrite RegWrite  datapath enables/selects
//   ResultSlc InputA InputB ImmSlc AluOpcode  datapath mux/ALU controls
module risc_v_multicycle_controller
  import risc_v_multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [2:0] Func3,
  input  logic       Func7,
  input  logic       ZeroFlag,
  input  logic       NegFlag,
  output logic       PCWrite,
  output logic       AdrSlc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSlc,
  output logic [1:0] InputA,
  output logic [1:0] InputB,
  output logic [2:0] ImmSlc,
  output logic [2:0] AluOpcode
);

  state_e     state_r;
  state_e     next_state_s;
  state_e     dec_state_s;
  logic [2:0] funct_alu_s;
  logic       pc_write_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;

  risc_v_alu_decoder u_alu_decoder (
    .opcode     (Opcode),
    .func3      (Func3),
    .func7      (Func7),
    .alu_opcode (funct_alu_s)
  );

  // While reset is high the outputs present FETCH, whatever state is held.
  assign dec_state_s = rst ? S_FETCH : state_r;

  // Writes are suppressed in the reset cycle so an aborted instruction leaves no trace.
  assign PCWrite  = pc_write_s  & ~rst;
  assign MemWrite = mem_write_s & ~rst;
  assign IRWrite  = ir_write_s  & ~rst;
  assign RegWrite = reg_write_s & ~rst;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    next_state_s = S_FETCH;
    pc_write_s   = 1'b0;
    AdrSlc       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    ResultSlc    = RES_ALUOUT;
    InputA       = A_PC;
    InputB       = B_REG;
    ImmSlc       = IMM_I;
    AluOpcode    = ALU_ADD;
    case (dec_state_s)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        InputA       = A_PC;
        InputB       = B_FOUR;
        ResultSlc    = RES_ALURESULT;
        pc_write_s   = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jal target into ALUOut.
        InputA = A_OLDPC;
        InputB = B_IMM;
        ImmSlc = (Opcode == OP_JAL) ? IMM_J : IMM_B;
        case (Opcode)
          OP_R_ALU:  next_state_s = S_EX_R;
          OP_I_ALU:  next_state_s = S_EX_I;
          OP_LOAD:   next_state_s = S_MEM_ADR;
          OP_STORE:  next_state_s = S_MEM_ADR;
          OP_BRANCH: next_state_s = S_BRANCH;
          OP_JAL:    next_state_s = S_JAL;
          OP_JALR:   next_state_s = S_JALR;
          OP_LUI:    next_state_s = S_LUI;
          default:   next_state_s = S_FETCH;
        endcase
      end
      S_EX_R: begin
        InputA       = A_REG;
        InputB       = B_REG;
        AluOpcode    = funct_alu_s;
        next_state_s = S_ALU_WB;
      end
      S_EX_I: begin
        InputA       = A_REG;
        InputB       = B_IMM;
        AluOpcode    = funct_alu_s;
        next_state_s = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_ADR: begin
        InputA       = A_REG;
        InputB       = B_IMM;
        ImmSlc       = (Opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state_s = (Opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        AdrSlc       = 1'b1;
        next_state_s = S_MEM_WB;
      end
      S_MEM_WB: begin
        ResultSlc    = RES_MDR;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WR: begin
        AdrSlc       = 1'b1;
        mem_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        // Compare by subtraction; blt/bge take the raw sign without overflow fix-up.
        InputA    = A_REG;
        InputB    = B_REG;
        AluOpcode = ALU_SUB;
        case (Func3)
          3'b000:  pc_write_s = ZeroFlag;
          3'b001:  pc_write_s = ~ZeroFlag;
          3'b100:  pc_write_s = NegFlag;
          3'b101:  pc_write_s = ~NegFlag;
          default: pc_write_s = 1'b0;
        endcase
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        pc_write_s   = 1'b1;
        next_state_s = S_LINK;
      end
      S_JALR: begin
        // PC is redirected here, before rd is written, so rd == rs1 is safe.
        InputA       = A_REG;
        InputB       = B_IMM;
        ResultSlc    = RES_ALURESULT;
        pc_write_s   = 1'b1;
        next_state_s = S_LINK;
      end
      S_LINK: begin
        InputA       = A_OLDPC;
        InputB       = B_FOUR;
        ResultSlc    = RES_ALURESULT;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_LUI: begin
        ImmSlc       = IMM_U;
        ResultSlc    = RES_IMMEXT;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

endmodule
